// File: rtl/fcpu_pkg.sv
// Shared fcpu widths, memory-channel opcodes and the mmu state encoding.
package fcpu_pkg;

    localparam int DATA_W   = 32;
    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 6;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    // Memory-channel opcodes. Other opcode values are accepted and dropped.
    localparam logic [INSTR_W-1:0] I_LOAD   = 6'h10;
    localparam logic [INSTR_W-1:0] I_LOADB  = 6'h11;
    localparam logic [INSTR_W-1:0] I_LOADR  = 6'h12;
    localparam logic [INSTR_W-1:0] I_STORE  = 6'h13;
    localparam logic [INSTR_W-1:0] I_STOREB = 6'h14;
    localparam logic [INSTR_W-1:0] I_STORER = 6'h15;
    localparam logic [INSTR_W-1:0] I_INPUT  = 6'h16;
    localparam logic [INSTR_W-1:0] I_OUTPUT = 6'h17;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RESP     = 3'd2,
        IN_WAIT  = 3'd3,
        OUT_WAIT = 3'd4
    } mmu_state_t;

    // One-hot byte write enable for a little-endian lane (lane 0 = bits 7:0).
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM: byte write enables, read-first, one-cycle read latency.
// No reset on the array or read register so it maps onto block RAM.
module dmem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Byte-lane writes and a read-first registered read of the same word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mmu.sv
// Memory-side responder: one load/store/input/output request at a time
// against a private data RAM or a byte-stream port; load and input results
// are returned on the CDB as {rsv_id, data}.
//
// Handshakes: every channel transfers on a cycle where its valid and ready
// are both high at the rising edge. A producer holds valid and its payload
// stable until that transfer; ready here is decoded from registered state
// only and never looks at the matching valid.
module mmu
    import fcpu_pkg::*;
#(
    parameter int DMEM_ADDR_W = 12
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_valid,
    input  logic [RSV_ID_W-1:0] i_rsv_id,
    input  logic [INSTR_W-1:0]  i_opcode,
    input  logic [DATA_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_data,
    output logic                i_ready,
    output logic [CDB_W-1:0]    o_cdb,
    output logic                o_cdb_valid,
    input  logic                o_cdb_ready,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          fsm_state
);

    mmu_state_t          state, state_next;
    logic [RSV_ID_W-1:0] tag_q;
    logic [1:0]          lane_q;
    logic                byte_q;
    logic [7:0]          out_byte;
    logic [CDB_W-1:0]    cdb_q, cdb_next;
    logic                cdb_load, req_latch, out_latch;
    logic                accept;
    logic [3:0]          ram_we;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata, load_data;
    logic [7:0]          load_byte;

    // Address bits above the RAM index are ignored so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[DATA_W-1:DMEM_ADDR_W+2];

    assign accept = i_valid && (state == IDLE);

    // Byte stores replicate the byte to every lane; the enable picks one.
    assign ram_wdata = (i_opcode == I_STOREB) ? {4{i_data[7:0]}} : i_data;

    dmem_ram #(
        .ADDR_W(DMEM_ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .addr  (i_addr[DMEM_ADDR_W+1:2]),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign load_byte = ram_rdata[{lane_q, 3'b000} +: 8];
    assign load_data = byte_q ? {{(DATA_W-8){1'b0}}, load_byte} : ram_rdata;

    // State register; reset aborts any request and drops a pending result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the write enable and register-load strobes.
    always_comb begin
        state_next = state;
        ram_we     = 4'b0000;
        req_latch  = 1'b0;
        out_latch  = 1'b0;
        cdb_load   = 1'b0;
        cdb_next   = cdb_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (i_opcode)
                        I_STORE, I_STORER: ram_we = 4'b1111;
                        I_STOREB:          ram_we = lane_mask(i_addr[1:0]);
                        I_LOAD, I_LOADR, I_LOADB: begin
                            req_latch  = 1'b1;
                            state_next = RD;
                        end
                        I_INPUT: begin
                            req_latch  = 1'b1;
                            state_next = IN_WAIT;
                        end
                        I_OUTPUT: begin
                            out_latch  = 1'b1;
                            state_next = OUT_WAIT;
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
            RD: begin
                cdb_load   = 1'b1;
                cdb_next   = {tag_q, load_data};
                state_next = RESP;
            end
            RESP: begin
                if (o_cdb_ready) begin
                    state_next = IDLE;
                end
            end
            IN_WAIT: begin
                if (in_valid) begin
                    cdb_load   = 1'b1;
                    cdb_next   = {tag_q, {(DATA_W-8){1'b0}}, in_data};
                    state_next = RESP;
                end
            end
            OUT_WAIT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request context, output byte and the CDB result register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tag_q    <= '0;
            lane_q   <= 2'b00;
            byte_q   <= 1'b0;
            out_byte <= 8'h00;
            cdb_q    <= '0;
        end else begin
            if (req_latch) begin
                tag_q  <= i_rsv_id;
                lane_q <= i_addr[1:0];
                byte_q <= (i_opcode == I_LOADB);
            end
            if (out_latch) begin
                out_byte <= i_data[7:0];
            end
            if (cdb_load) begin
                cdb_q <= cdb_next;
            end
        end
    end

    assign i_ready     = (state == IDLE);
    assign o_cdb_valid = (state == RESP);
    assign o_cdb       = cdb_q;
    assign in_ready    = (state == IN_WAIT);
    assign out_valid   = (state == OUT_WAIT);
    assign out_data    = out_byte;
    assign fsm_state   = state;

endmodule

// File: doc/mmu.md
# mmu

Memory-side responder for the fcpu memory request channel. It accepts one load, store, input or output request at a time from the core's memory functional unit and performs it against a private data RAM or a byte-stream I/O port. Load and input results go back onto the common data bus (CDB) as `{rsv_id, data}` through a valid/ready port. Stores and outputs produce no CDB traffic, because the reorder buffer already retired them as no-wait entries.

## Interface
Parameters:
- `DMEM_ADDR_W`, default 12: data RAM word-address width (4096 × 32-bit words).

Ports:
- `clk`  in  1: system clock; all state is on the rising edge.
- `nrst`  in  1: reset, asynchronous, active-low.
- `i_valid`  in  1: request valid.
- `i_rsv_id`  in  RSV_ID_W: reorder-buffer tag of the request.
- `i_opcode`  in  INSTR_W: one of I_LOAD, I_LOADB, I_LOADR, I_STORE, I_STOREB, I_STORER, I_INPUT, I_OUTPUT.
- `i_addr`  in  DATA_W: byte address.
- `i_data`  in  DATA_W: store or output data.
- `i_ready`  out  1: request accepted when `i_valid && i_ready`.
- `o_cdb`  out  CDB_W: `{rsv_id, data}`; the tag sits at `[DATA_W+:RSV_ID_W]`.
- `o_cdb_valid`  out  1: CDB result valid.
- `o_cdb_ready`  in  1: CDB arbiter grant.
- `in_data`  in  8: input byte stream data.
- `in_valid`  in  1: input byte available.
- `in_ready`  out  1: input byte consumed.
- `out_data`  out  8: output byte.
- `out_valid`  out  1: output byte valid.
- `out_ready`  in  1: output sink accepts the byte.

## Operation
- **FSM states:**
  - IDLE: `i_ready` = 1.
  - RD: RAM read in flight.
  - RESP: hold the CDB result.
  - IN_WAIT: wait for an input byte.
  - OUT_WAIT: wait for the output sink.
- **Addressing:**
  - Word index is `i_addr[DMEM_ADDR_W+1:2]`; upper bits are ignored, so addresses wrap.
  - Word ops ignore `i_addr[1:0]`.
  - Byte ops select lane `i_addr[1:0]`, little-endian (lane 0 = bits 7:0).
- **IDLE, on accept, by opcode:**
  - STORE / STORER: write the whole word on the accept cycle; stay in IDLE.
  - STOREB: write `i_data[7:0]` to the selected lane only (byte write enable); stay in IDLE.
  - LOAD / LOADR / LOADB: issue the RAM read; latch `i_rsv_id`, byte lane and a byte flag; go to RD.
  - INPUT: latch the tag; go to IN_WAIT.
  - OUTPUT: latch `i_data[7:0]`; go to OUT_WAIT.
  - Any other opcode: accept and drop; stay in IDLE; no response.
- **RD:** the RAM output is valid this cycle.
  - Data is the full word, or for LOADB the selected byte zero-extended to DATA_W.
  - Register `{tag, data}` into `o_cdb`; go to RESP.
- **RESP:** `o_cdb_valid` = 1 with `o_cdb` stable. On `o_cdb_ready`, go to IDLE.
- **IN_WAIT:** `in_ready` = 1. When `in_valid`, load `o_cdb` = `{tag, 24'b0, in_data}` and go to RESP.
- **OUT_WAIT:** `out_valid` = 1 and `out_data` = latched byte. On `out_ready`, go to IDLE.
- **Simultaneous events:** CDB results are never lost or reordered, because only one request is outstanding at a time.
- **Reset:** asserting `nrst` mid-operation aborts everything, returns the FSM to IDLE and drops any pending result. RAM contents are not reset.

## Timing
- **Reset values:**
  - `i_ready` = 1.
  - `o_cdb_valid` = 0, `o_cdb` = 0.
  - `in_ready` = 0.
  - `out_valid` = 0, `out_data` = 0.
- **Store:** accepted at cycle t; the write is visible to a load accepted at t+1. Stores sustain one per cycle.
- **Load:** accepted at t; `o_cdb_valid` rises at t+2; the next request is accepted no earlier than the cycle after the `o_cdb_ready` handshake.
- **Input:** `o_cdb_valid` rises the cycle after the `in_valid && in_ready` handshake.
- **Output:** `out_valid` rises at t+1; `i_ready` returns the cycle after `out_ready`.
- **Handshake stability:**
  - `o_cdb` / `o_cdb_valid` are held stable until `o_cdb_ready`.
  - `out_data` / `out_valid` are held stable until `out_ready`.
- **Ready rule:** `i_ready` is a registered function of state only (high only in IDLE); it never depends combinationally on `i_valid`.

## Structure
- **From `fcpu_pkg`:** `DATA_W`, `RSV_ID_W`, `INSTR_W`, `CDB_W`, the `I_*` opcode constants, plus a new `mmu_state_t` enum (IDLE, RD, RESP, IN_WAIT, OUT_WAIT) added to the package.
- **Sub-module `dmem_ram`:**
  - Single-port synchronous RAM, 2^DMEM_ADDR_W × 32 bits.
  - 4-bit byte write enable; read-first; one-cycle read latency.
  - Written for BRAM inference.

## Test plan
- **Word store then load:** STORE addr 0x10 data 0xDEADBEEF tag 3, then LOAD addr 0x10 tag 5 → `o_cdb` = {5, 0xDEADBEEF} exactly 2 cycles after the load is accepted.
- **Byte ops:** STOREB addr 0x21 data 0xAB over a word preloaded with 0x11223344 → LOADR 0x20 returns 0x1122AB44; LOADB 0x21 returns 0x000000AB.
- **CDB backpressure:** hold `o_cdb_ready` = 0 for 5 cycles after a load → `o_cdb` stable, `i_ready` = 0 throughout; release → result consumed, `i_ready` = 1 the next cycle.
- **I/O:** INPUT tag 7 with `in_valid` delayed 4 cycles, byte 0x5A → `o_cdb` = {7, 0x0000005A}. OUTPUT data 0x1234_0041 with `out_ready` low for 3 cycles → `out_data` = 0x41 held, exactly one transfer.
- **Wrap and reset:** STORE at address (4 << DMEM_ADDR_W) + 8 aliases word 2. Asserting `nrst` while in RESP → `o_cdb_valid` drops immediately, `i_ready` = 1 after release, RAM data preserved.
